// File: rtl/mem_access_unit_pkg.sv
// Shared LC-3b types for the MEM-stage data-memory sequencer: memory op
// encoding, word type and the sequencer state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    MEM_NONE = 3'd0,
    MEM_LDW  = 3'd1,
    MEM_LDB  = 3'd2,
    MEM_STW  = 3'd3,
    MEM_STB  = 3'd4,
    MEM_LDI  = 3'd5,
    MEM_STI  = 3'd6
  } lc3b_mem_op;

  typedef enum logic {
    FIRST  = 1'b0,
    SECOND = 1'b1
  } mem_access_state_t;

  function automatic logic is_indirect(lc3b_mem_op op);
    return (op == MEM_LDI) || (op == MEM_STI);
  endfunction

  function automatic logic is_single(lc3b_mem_op op);
    return (op == MEM_LDW) || (op == MEM_LDB) || (op == MEM_STW) || (op == MEM_STB);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage sequencer (master)
// and the data memory (slave). The memory holds a request until dmem_resp.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  dmem_read;
  logic                  dmem_write;
  logic [ADDR_WIDTH-1:0] dmem_address;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic [1:0]            dmem_byte_enable;
  logic                  dmem_resp;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_byte_lane.sv
// Byte-lane steering for the two-lane data memory: lane enables, store byte
// replication and load byte select with zero extension.
module mem_byte_lane
  import lc3b_types::*;
(
  input  lc3b_mem_op op,
  input  logic       addr_lsb,
  input  lc3b_word   store_src,
  input  lc3b_word   load_src,
  output logic [1:0] byte_enable,
  output lc3b_word   store_data,
  output lc3b_word   load_data
);

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_enable = 2'b11;
    store_data  = store_src;
    load_data   = load_src;
    case (op)
      MEM_NONE: byte_enable = 2'b00;
      MEM_LDB: begin
        byte_enable = addr_lsb ? 2'b10 : 2'b01;
        load_data   = {8'h00, (addr_lsb ? load_src[15:8] : load_src[7:0])};
      end
      MEM_STB: begin
        byte_enable = addr_lsb ? 2'b10 : 2'b01;
        store_data  = {store_src[7:0], store_src[7:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: issues single loads/stores directly and
// LDI/STI as a pointer fetch followed by the data access, freezing the pipe.
module mem_access_unit
  import lc3b_types::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  lc3b_mem_op            mem_op,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  mem_access_unit_if.master     dmem,
  output logic [DATA_WIDTH-1:0] mem_result,
  output logic                  mem_indirect_stall
);

  mem_access_state_t     state, state_next;
  logic [ADDR_WIDTH-1:1] ptr_reg;
  logic                  ptr_load;
  logic [1:0]            lane_be;
  lc3b_word              lane_store, lane_load;

  mem_byte_lane u_byte_lane (
    .op          (mem_op),
    .addr_lsb    (mem_addr[0]),
    .store_src   (mem_wdata),
    .load_src    (dmem.dmem_rdata),
    .byte_enable (lane_be),
    .store_data  (lane_store),
    .load_data   (lane_load)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FIRST;
      ptr_reg <= '0;
    end else begin
      state <= state_next;
      if (ptr_load) ptr_reg <= dmem.dmem_rdata[ADDR_WIDTH-1:1];
    end
  end

  always_comb begin
    state_next            = state;
    ptr_load              = 1'b0;
    dmem.dmem_read        = 1'b0;
    dmem.dmem_write       = 1'b0;
    dmem.dmem_address     = '0;
    dmem.dmem_wdata       = '0;
    dmem.dmem_byte_enable = 2'b00;
    mem_result            = '0;
    mem_indirect_stall    = 1'b0;

    if (!reset) begin
      case (state)
        FIRST: begin
          if (mem_op != MEM_NONE) begin
            dmem.dmem_read        = (mem_op == MEM_LDW) || (mem_op == MEM_LDB) || is_indirect(mem_op);
            dmem.dmem_write       = (mem_op == MEM_STW) || (mem_op == MEM_STB);
            // Byte ops keep the raw address; everything else is word aligned.
            dmem.dmem_address     = ((mem_op == MEM_LDB) || (mem_op == MEM_STB)) ?
                                    mem_addr : {mem_addr[ADDR_WIDTH-1:1], 1'b0};
            dmem.dmem_byte_enable = lane_be;
            dmem.dmem_wdata       = dmem.dmem_write ? lane_store : '0;
            mem_indirect_stall    = !(dmem.dmem_resp && is_single(mem_op));
          end
          if ((mem_op == MEM_LDW) || (mem_op == MEM_LDB)) mem_result = lane_load;
          if (dmem.dmem_resp && is_indirect(mem_op)) begin
            ptr_load   = 1'b1;
            state_next = SECOND;
          end
        end

        SECOND: begin
          dmem.dmem_read        = (mem_op == MEM_LDI);
          dmem.dmem_write       = (mem_op == MEM_STI);
          dmem.dmem_address     = {ptr_reg, 1'b0};
          dmem.dmem_byte_enable = 2'b11;
          dmem.dmem_wdata       = (mem_op == MEM_STI) ? mem_wdata : '0;
          mem_indirect_stall    = !dmem.dmem_resp;
          if (dmem.dmem_resp) begin
            if (mem_op == MEM_LDI) mem_result = dmem.dmem_rdata;
            state_next = FIRST;
          end
        end

        default: state_next = FIRST;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// spurious-response sequences, and random ops against a behavioural memory model.
module tb_mem_access_unit;
  import lc3b_types::*;

  logic        clk = 1'b0;
  logic        reset;
  lc3b_mem_op  mem_op;
  logic [15:0] mem_addr, mem_wdata, mem_result;
  logic        mem_indirect_stall;

  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dmem ();

  mem_access_unit #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_op             (mem_op),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .dmem               (dmem),
    .mem_result         (mem_result),
    .mem_indirect_stall (mem_indirect_stall)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word-addressed data memory; unwritten words read a fixed address-derived pattern.
  logic [15:0] mem [logic [14:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    logic [14:0] w;
    w = a[15:1];
    return mem.exists(w) ? mem[w] : ({w, 1'b0} ^ 16'h9C3B);
  endfunction

  task automatic mem_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] cur;
    cur = mem_rd(a);
    if (be[0]) cur[7:0]  = d[7:0];
    if (be[1]) cur[15:8] = d[15:8];
    mem[a[15:1]] = cur;
  endtask

  // Expected bus activity and result of one pipeline memory op.
  typedef struct {
    int          nacc;
    logic        wr0, wr1;
    logic [15:0] a0, a1;
    logic [1:0]  be0, be1;
    logic [15:0] wd0, wd1;
    logic        chk_res;
    logic [15:0] res;
  } exp_t;

  function automatic exp_t model(input lc3b_mem_op op, input logic [15:0] addr,
                                 input logic [15:0] wdata);
    exp_t        e;
    logic [15:0] word_addr, w, ptr;
    word_addr = addr - (addr % 2);
    w         = mem_rd(addr);
    e.nacc = 1; e.wr0 = 0; e.wr1 = 0; e.a0 = word_addr; e.a1 = 0;
    e.be0 = 2'b11; e.be1 = 2'b11; e.wd0 = 0; e.wd1 = 0; e.chk_res = 0; e.res = 0;
    case (op)
      MEM_LDW: begin e.chk_res = 1; e.res = w; end
      MEM_LDB: begin
        e.a0 = addr; e.be0 = (addr % 2 == 1) ? 2'b10 : 2'b01; e.chk_res = 1;
        e.res = (addr % 2 == 1) ? w / 256 : w % 256;
      end
      MEM_STW: begin e.wr0 = 1; e.wd0 = wdata; end
      MEM_STB: begin
        e.wr0 = 1; e.a0 = addr; e.be0 = (addr % 2 == 1) ? 2'b10 : 2'b01;
        e.wd0 = (wdata % 256) * 16'h0101;
      end
      MEM_LDI, MEM_STI: begin
        ptr = w;
        e.nacc = 2; e.a1 = ptr - (ptr % 2); e.chk_res = 1;
        if (op == MEM_LDI) e.res = mem_rd(ptr);
        else begin e.wr1 = 1; e.wd1 = wdata; e.res = 0; end
      end
      default: e.nacc = 0;
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic do_txn(input lc3b_mem_op op, input logic [15:0] addr, input logic [15:0] wdata,
                        input int n1, input int n2, input exp_t e, input string tag);
    mem_op    = op;
    mem_addr  = addr;
    mem_wdata = wdata;
    for (int j = 0; j < e.nacc; j++) begin
      int          n;
      logic        wr;
      logic [15:0] ea, ewd;
      logic [1:0]  ebe;
      n   = (j == 0) ? n1 : n2;
      wr  = (j == 0) ? e.wr0 : e.wr1;
      ea  = (j == 0) ? e.a0 : e.a1;
      ebe = (j == 0) ? e.be0 : e.be1;
      ewd = (j == 0) ? e.wd0 : e.wd1;
      for (int k = 0; k <= n; k++) begin
        dmem.dmem_resp = 1'b0;
        #1;
        check({tag, ".read"},  32'(dmem.dmem_read),  32'(!wr));
        check({tag, ".write"}, 32'(dmem.dmem_write), 32'(wr));
        check({tag, ".addr"},  32'(dmem.dmem_address), 32'(ea));
        check({tag, ".be"},    32'(dmem.dmem_byte_enable), 32'(ebe));
        if (wr) check({tag, ".wdata"}, 32'(dmem.dmem_wdata), 32'(ewd));
        if (k == n) begin
          dmem.dmem_resp  = 1'b1;
          dmem.dmem_rdata = mem_rd(dmem.dmem_address);
          if (dmem.dmem_write) mem_wr(dmem.dmem_address, dmem.dmem_wdata, dmem.dmem_byte_enable);
          #1;
          check({tag, ".stall_resp"}, 32'(mem_indirect_stall), 32'(j + 1 < e.nacc));
          if (j + 1 == e.nacc && e.chk_res) check({tag, ".result"}, 32'(mem_result), 32'(e.res));
        end else begin
          dmem.dmem_rdata = 16'($urandom);
          #1;
          check({tag, ".stall_wait"}, 32'(mem_indirect_stall), 32'd1);
        end
        @(posedge clk); #1;
      end
    end
    dmem.dmem_resp = 1'b0;
  endtask

  typedef struct {
    lc3b_mem_op  op;
    logic [15:0] addr, wdata;
    int          n1, n2;
    logic [15:0] pa, pd, qa, qd;
    logic [15:0] a0, a1;
    logic [1:0]  be;
    logic [15:0] wd, res;
  } vec_t;

  vec_t vecs [8];

  initial begin
    exp_t e;
    vecs[0] = '{MEM_LDW, 16'h1235, 16'h0000, 2, 0, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF,
                16'h1234, 16'h0000, 2'b11, 16'h0000, 16'hBEEF};
    vecs[1] = '{MEM_STB, 16'h2001, 16'h00A5, 1, 0, 16'h2000, 16'h0000, 16'h2000, 16'h0000,
                16'h2001, 16'h0000, 2'b10, 16'hA5A5, 16'h0000};
    vecs[2] = '{MEM_LDB, 16'h3000, 16'h0000, 0, 0, 16'h3000, 16'h7F80, 16'h3000, 16'h7F80,
                16'h3000, 16'h0000, 2'b01, 16'h0000, 16'h0080};
    vecs[3] = '{MEM_LDB, 16'h3001, 16'h0000, 1, 0, 16'h3000, 16'h7F80, 16'h3000, 16'h7F80,
                16'h3001, 16'h0000, 2'b10, 16'h0000, 16'h007F};
    vecs[4] = '{MEM_LDI, 16'h4000, 16'h0000, 1, 2, 16'h4000, 16'h5002, 16'h5002, 16'h1357,
                16'h4000, 16'h5002, 2'b11, 16'h0000, 16'h1357};
    vecs[5] = '{MEM_STI, 16'h4000, 16'hCAFE, 0, 1, 16'h4000, 16'h6000, 16'h6000, 16'h0000,
                16'h4000, 16'h6000, 2'b11, 16'hCAFE, 16'h0000};
    vecs[6] = '{MEM_STW, 16'h7003, 16'h1234, 0, 0, 16'h7002, 16'hFFFF, 16'h7002, 16'hFFFF,
                16'h7002, 16'h0000, 2'b11, 16'h1234, 16'h0000};
    vecs[7] = '{MEM_LDI, 16'h4010, 16'h0000, 0, 0, 16'h4010, 16'h6101, 16'h6100, 16'hABCD,
                16'h4010, 16'h6100, 2'b11, 16'h0000, 16'hABCD};

    // Reset: outputs forced low even with an op and a response present.
    reset = 1'b1; mem_op = MEM_LDW; mem_addr = 16'h1234; mem_wdata = 16'h5555;
    dmem.dmem_resp = 1'b0; dmem.dmem_rdata = 16'h0000;
    @(posedge clk); #1;
    dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'hFFFF;
    #1;
    check("rst.read",   32'(dmem.dmem_read), 0);
    check("rst.write",  32'(dmem.dmem_write), 0);
    check("rst.stall",  32'(mem_indirect_stall), 0);
    check("rst.result", 32'(mem_result), 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_op = MEM_NONE; dmem.dmem_resp = 1'b0;
    @(posedge clk); #1;

    // Response with nothing pending is ignored.
    dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'hFFFF;
    #1;
    check("idle.read",   32'(dmem.dmem_read), 0);
    check("idle.write",  32'(dmem.dmem_write), 0);
    check("idle.stall",  32'(mem_indirect_stall), 0);
    check("idle.result", 32'(mem_result), 0);
    @(posedge clk); #1;
    dmem.dmem_resp = 1'b0;

    // Directed vectors, issued back to back.
    for (int i = 0; i < 8; i++) begin
      mem[vecs[i].pa[15:1]] = vecs[i].pd;
      mem[vecs[i].qa[15:1]] = vecs[i].qd;
      e.nacc    = ((vecs[i].op == MEM_LDI) || (vecs[i].op == MEM_STI)) ? 2 : 1;
      e.wr0     = (vecs[i].op == MEM_STW) || (vecs[i].op == MEM_STB);
      e.a0      = vecs[i].a0;
      e.be0     = (e.nacc == 2) ? 2'b11 : vecs[i].be;
      e.wd0     = vecs[i].wd;
      e.wr1     = (vecs[i].op == MEM_STI);
      e.a1      = vecs[i].a1;
      e.be1     = 2'b11;
      e.wd1     = vecs[i].wd;
      e.chk_res = !e.wr0;
      e.res     = vecs[i].res;
      do_txn(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].n1, vecs[i].n2, e,
             $sformatf("vec%0d", i));
    end
    mem_op = MEM_NONE;
    check("mem.sti",  32'(mem_rd(16'h6000)), 32'h0000CAFE);
    check("mem.stb",  32'(mem_rd(16'h2000)), 32'h0000A500);
    check("mem.stw",  32'(mem_rd(16'h7002)), 32'h00001234);

    // Reset while LDI waits on its second access.
    @(posedge clk); #1;
    mem_op = MEM_LDI; mem_addr = 16'h4101; mem_wdata = 16'h0000;
    #1;
    check("rstmid.ptr_read", 32'(dmem.dmem_read), 1);
    check("rstmid.ptr_addr", 32'(dmem.dmem_address), 32'h4100);
    dmem.dmem_resp = 1'b1; dmem.dmem_rdata = 16'h5554;
    #1;
    check("rstmid.ptr_stall", 32'(mem_indirect_stall), 1);
    @(posedge clk); #1;
    dmem.dmem_resp = 1'b0;
    #1;
    check("rstmid.second_read", 32'(dmem.dmem_read), 1);
    check("rstmid.second_addr", 32'(dmem.dmem_address), 32'h5554);
    check("rstmid.second_stall", 32'(mem_indirect_stall), 1);
    reset = 1'b1;
    #1;
    check("rstmid.in_rst_read",  32'(dmem.dmem_read), 0);
    check("rstmid.in_rst_stall", 32'(mem_indirect_stall), 0);
    @(posedge clk); #1;
    reset = 1'b0; mem_op = MEM_NONE;
    #1;
    check("rstmid.after_read",  32'(dmem.dmem_read), 0);
    check("rstmid.after_write", 32'(dmem.dmem_write), 0);
    check("rstmid.after_stall", 32'(mem_indirect_stall), 0);
    @(posedge clk); #1;
    mem[16'h1230 >> 1] = 16'h2468;
    e = model(MEM_LDW, 16'h1231, 16'h0000);
    do_txn(MEM_LDW, 16'h1231, 16'h0000, 1, 0, e, "rstmid.ldw");
    mem_op = MEM_NONE;

    // Random ops over a small address pool so stores feed later loads.
    for (int i = 0; i < 40; i++) begin
      lc3b_mem_op  op;
      logic [15:0] a, wd;
      int          n1, n2;
      op = lc3b_mem_op'($urandom_range(1, 6));
      a  = 16'h8000 + 16'($urandom_range(0, 15));
      wd = 16'($urandom);
      n1 = $urandom_range(0, 3);
      n2 = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        mem[a[15:1]] = 16'h8000 + 16'($urandom_range(0, 15));
      end
      e = model(op, a, wd);
      do_txn(op, a, wd, n1, n2, e, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 2) == 0) begin
        mem_op = MEM_NONE;
        #1;
        check($sformatf("rnd%0d.gap_stall", i), 32'(mem_indirect_stall), 0);
        @(posedge clk); #1;
      end
    end
    mem_op = MEM_NONE;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
